// File: rtl/axi_pkg.sv
// Shared AXI3 encodings and FSM state types for the SRAM responder and its
// address sequencer.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3 bus bundle between a master and the SRAM responder; lock/cache/prot and
// wid are carried for completeness but the responder ignores them.
interface axi_sram_slave_if #(parameter int ID_WIDTH = 4);

    logic [ID_WIDTH-1:0] arid;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;

    logic [ID_WIDTH-1:0] rid;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    logic [ID_WIDTH-1:0] awid;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [1:0]          awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;

    logic [ID_WIDTH-1:0] wid;
    logic [31:0]         wdata;
    logic [3:0]          wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_WIDTH-1:0] bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

endinterface

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts; WRAP with an
// illegal length (not 2/4/8/16 beats) degrades to INCR.
module axi_burst_addr
    import axi_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [3:0]  len,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr
);

    logic [31:0] step;
    logic [31:0] incr_addr;
    logic [31:0] mask;
    logic        wrap_ok;

    always_comb begin
        step      = 32'd1 << size;
        incr_addr = addr + step;
        mask      = ((32'(len) + 32'd1) << size) - 32'd1;
        wrap_ok   = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        next_addr = incr_addr;
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = wrap_ok ? ((addr & ~mask) | (incr_addr & mask)) : incr_addr;
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 responder backed by a word-addressed RAM, with independent read and
// write FSMs each holding one outstanding burst.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int ID_WIDTH   = 4
)
(
    input logic             aclk,
    input logic             aresetn,
    axi_sram_slave_if.slave bus
);

    logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

    function automatic logic [ADDR_WIDTH-1:0] ram_index(input logic [31:0] a);
        return a[ADDR_WIDTH+1:2];
    endfunction

    r_state_t    r_state;
    logic [31:0] r_addr;
    logic [31:0] r_next;
    logic [3:0]  r_len;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic [3:0]  r_cnt;

    w_state_t    w_state;
    logic [31:0] w_addr;
    logic [31:0] w_next;
    logic [3:0]  w_len;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic [3:0]  w_cnt;
    logic        w_err;
    logic        w_beat;
    logic        last_beat;
    logic        wlast_bad;
    logic        unused_ok;

    axi_burst_addr u_rd_addr (.addr(r_addr), .len(r_len), .size(r_size), .burst(r_burst), .next_addr(r_next));
    axi_burst_addr u_wr_addr (.addr(w_addr), .len(w_len), .size(w_size), .burst(w_burst), .next_addr(w_next));

    assign w_beat    = (w_state == W_DATA) && bus.wvalid;
    assign last_beat = (w_cnt == w_len);
    assign wlast_bad = (bus.wlast != last_beat);
    assign unused_ok = ^{bus.arlen[7:4], bus.awlen[7:4], bus.arlock, bus.arcache, bus.arprot,
                         bus.awlock, bus.awcache, bus.awprot, bus.wid};

    // rdata is loaded on the same edge that accepts AR or consumes a beat,
    // so the first beat appears one cycle after AR with no bubbles after.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= R_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_burst     <= BURST_FIXED;
            r_cnt       <= '0;
            bus.arready <= 1'b1;
            bus.rvalid  <= 1'b0;
            bus.rdata   <= '0;
            bus.rlast   <= 1'b0;
            bus.rid     <= '0;
            bus.rresp   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: if (bus.arvalid) begin
                    r_addr      <= bus.araddr;
                    r_len       <= bus.arlen[3:0];
                    r_size      <= bus.arsize;
                    r_burst     <= bus.arburst;
                    r_cnt       <= '0;
                    bus.rid     <= bus.arid;
                    bus.rdata   <= mem[ram_index(bus.araddr)];
                    bus.rlast   <= (bus.arlen[3:0] == 4'd0);
                    bus.rvalid  <= 1'b1;
                    bus.arready <= 1'b0;
                    r_state     <= R_DATA;
                end
                R_DATA: if (bus.rready) begin
                    if (bus.rlast) begin
                        bus.rvalid  <= 1'b0;
                        bus.rlast   <= 1'b0;
                        bus.arready <= 1'b1;
                        r_state     <= R_IDLE;
                    end else begin
                        r_addr    <= r_next;
                        r_cnt     <= r_cnt + 4'd1;
                        bus.rdata <= mem[ram_index(r_next)];
                        bus.rlast <= ((r_cnt + 4'd1) == r_len);
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // The beat count, not wlast, ends a write burst; a wlast disagreement
    // only poisons the response with SLVERR.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state     <= W_IDLE;
            w_addr      <= '0;
            w_len       <= '0;
            w_size      <= '0;
            w_burst     <= BURST_FIXED;
            w_cnt       <= '0;
            w_err       <= 1'b0;
            bus.awready <= 1'b1;
            bus.wready  <= 1'b0;
            bus.bvalid  <= 1'b0;
            bus.bresp   <= RESP_OKAY;
            bus.bid     <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (bus.awvalid) begin
                    w_addr      <= bus.awaddr;
                    w_len       <= bus.awlen[3:0];
                    w_size      <= bus.awsize;
                    w_burst     <= bus.awburst;
                    w_cnt       <= '0;
                    w_err       <= 1'b0;
                    bus.bid     <= bus.awid;
                    bus.awready <= 1'b0;
                    bus.wready  <= 1'b1;
                    w_state     <= W_DATA;
                end
                W_DATA: if (bus.wvalid) begin
                    w_addr <= w_next;
                    w_cnt  <= w_cnt + 4'd1;
                    if (wlast_bad) w_err <= 1'b1;
                    if (last_beat) begin
                        bus.wready <= 1'b0;
                        bus.bvalid <= 1'b1;
                        bus.bresp  <= (w_err || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
                        w_state    <= W_RESP;
                    end
                end
                W_RESP: if (bus.bready) begin
                    bus.bvalid  <= 1'b0;
                    bus.awready <= 1'b1;
                    w_state     <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (w_beat) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i]) mem[ram_index(w_addr)][8*i +: 8] <= bus.wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: writes and reads bursts through the AXI
// interface and compares every response field against hand-computed values.
module tb_axi_sram_slave;
    import axi_pkg::*;

    localparam int WAIT_LIMIT = 50;

    logic aclk;
    logic aresetn;
    int   vectors;
    int   miscompares;

    logic [31:0] wdata_q [16];
    logic [3:0]  wstrb_q [16];
    logic [31:0] rexp_q  [16];

    axi_sram_slave_if #(.ID_WIDTH(4)) bus ();

    axi_sram_slave #(.ADDR_WIDTH(12), .ID_WIDTH(4)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic writeBurst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                              input logic [1:0] burst, input logic bad_wlast, input logic [1:0] exp_resp);
        int n;
        bus.awid = id; bus.awaddr = addr; bus.awlen = {4'd0, len};
        bus.awsize = 3'd2; bus.awburst = burst; bus.awvalid = 1'b1;
        n = 0;
        while (bus.awready !== 1'b1 && n < WAIT_LIMIT) begin tick(); n++; end
        checkOutput("awready", 32'(bus.awready), 32'd1);
        tick();
        bus.awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            bus.wvalid = 1'b1;
            bus.wdata  = wdata_q[b];
            bus.wstrb  = wstrb_q[b];
            bus.wlast  = bad_wlast ? (b == 0) : (b == int'(len));
            n = 0;
            while (bus.wready !== 1'b1 && n < WAIT_LIMIT) begin tick(); n++; end
            checkOutput($sformatf("wready[%0d]", b), 32'(bus.wready), 32'd1);
            tick();
        end
        bus.wvalid = 1'b0;
        bus.wlast  = 1'b0;
        checkOutput("wready_done", 32'(bus.wready), 32'd0);
        checkOutput("bvalid", 32'(bus.bvalid), 32'd1);
        checkOutput("bresp", 32'(bus.bresp), 32'(exp_resp));
        checkOutput("bid", 32'(bus.bid), 32'(id));
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        checkOutput("bvalid_clear", 32'(bus.bvalid), 32'd0);
    endtask

    task automatic readBurst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [1:0] burst);
        int n;
        bus.arid = id; bus.araddr = addr; bus.arlen = {4'd0, len};
        bus.arsize = 3'd2; bus.arburst = burst; bus.arvalid = 1'b1;
        bus.rready = 1'b1;
        n = 0;
        while (bus.arready !== 1'b1 && n < WAIT_LIMIT) begin tick(); n++; end
        checkOutput("arready", 32'(bus.arready), 32'd1);
        tick();
        bus.arvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            checkOutput($sformatf("rvalid[%0d]", b), 32'(bus.rvalid), 32'd1);
            checkOutput($sformatf("rdata[%0d]", b), bus.rdata, rexp_q[b]);
            checkOutput($sformatf("rlast[%0d]", b), 32'(bus.rlast), 32'(b == int'(len)));
            checkOutput($sformatf("rid[%0d]", b), 32'(bus.rid), 32'(id));
            checkOutput($sformatf("rresp[%0d]", b), 32'(bus.rresp), 32'(RESP_OKAY));
            tick();
        end
        bus.rready = 1'b0;
        checkOutput("rvalid_end", 32'(bus.rvalid), 32'd0);
    endtask

    task automatic applyStimulus();
        // Reset values
        aresetn = 1'b1;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b0;
        #1 aresetn = 1'b0;
        #2;
        checkOutput("rst_arready", 32'(bus.arready), 32'd1);
        checkOutput("rst_awready", 32'(bus.awready), 32'd1);
        checkOutput("rst_rvalid", 32'(bus.rvalid), 32'd0);
        checkOutput("rst_wready", 32'(bus.wready), 32'd0);
        checkOutput("rst_bvalid", 32'(bus.bvalid), 32'd0);
        checkOutput("rst_rlast", 32'(bus.rlast), 32'd0);
        checkOutput("rst_rdata", bus.rdata, 32'd0);
        checkOutput("rst_ids", 32'({bus.rid, bus.bid, bus.rresp, bus.bresp}), 32'd0);
        tick();
        aresetn = 1'b1;
        tick();

        // Single write then read
        wdata_q[0] = 32'hDEADBEEF; wstrb_q[0] = 4'hF;
        writeBurst(4'h5, 32'h100, 4'd0, BURST_INCR, 1'b0, RESP_OKAY);
        rexp_q[0] = 32'hDEADBEEF;
        readBurst(4'h9, 32'h100, 4'd0, BURST_INCR);

        // INCR burst, back-to-back read
        for (int i = 0; i < 4; i++) begin wdata_q[i] = 32'(i + 1); wstrb_q[i] = 4'hF; rexp_q[i] = 32'(i + 1); end
        writeBurst(4'h1, 32'h200, 4'd3, BURST_INCR, 1'b0, RESP_OKAY);
        readBurst(4'h2, 32'h200, 4'd3, BURST_INCR);

        // FIXED read repeats one word
        rexp_q[0] = 32'hDEADBEEF; rexp_q[1] = 32'hDEADBEEF;
        readBurst(4'h3, 32'h100, 4'd1, BURST_FIXED);

        // WRAP: 0x308 -> 0x30C -> 0x300 -> 0x304
        wdata_q[0] = 32'hA; wdata_q[1] = 32'hB; wdata_q[2] = 32'hC; wdata_q[3] = 32'hD;
        writeBurst(4'h4, 32'h300, 4'd3, BURST_INCR, 1'b0, RESP_OKAY);
        rexp_q[0] = 32'hC; rexp_q[1] = 32'hD; rexp_q[2] = 32'hA; rexp_q[3] = 32'hB;
        readBurst(4'hA, 32'h308, 4'd3, BURST_WRAP);

        // Byte strobes: lanes 0 and 2 replaced
        wdata_q[0] = 32'h11223344; wstrb_q[0] = 4'hF;
        writeBurst(4'h6, 32'h40, 4'd0, BURST_INCR, 1'b0, RESP_OKAY);
        wdata_q[0] = 32'hAABBCCDD; wstrb_q[0] = 4'b0101;
        writeBurst(4'h6, 32'h40, 4'd0, BURST_INCR, 1'b0, RESP_OKAY);
        rexp_q[0] = 32'h11BB33DD;
        readBurst(4'h6, 32'h40, 4'd0, BURST_INCR);

        // Backpressure holds rdata/rlast
        bus.arid = 4'h7; bus.araddr = 32'h200; bus.arlen = 8'd3; bus.arsize = 3'd2;
        bus.arburst = BURST_INCR; bus.arvalid = 1'b1; bus.rready = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        checkOutput("bp_beat0", bus.rdata, 32'd1);
        tick();
        bus.rready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("bp_hold_rdata", bus.rdata, 32'd2);
            checkOutput("bp_hold_rlast", 32'(bus.rlast), 32'd0);
            checkOutput("bp_hold_rvalid", 32'(bus.rvalid), 32'd1);
        end
        bus.rready = 1'b1;
        for (int b = 1; b < 4; b++) begin
            checkOutput($sformatf("bp_rdata[%0d]", b), bus.rdata, 32'(b + 1));
            checkOutput($sformatf("bp_rlast[%0d]", b), 32'(bus.rlast), 32'(b == 3));
            tick();
        end
        bus.rready = 1'b0;
        checkOutput("bp_rvalid_end", 32'(bus.rvalid), 32'd0);

        // Early wlast: still two beats, then SLVERR
        wdata_q[0] = 32'h0; wdata_q[1] = 32'h0; wstrb_q[0] = 4'h0; wstrb_q[1] = 4'h0;
        writeBurst(4'hC, 32'h600, 4'd1, BURST_INCR, 1'b1, RESP_SLVERR);

        // AR accepted on the same edge as a write beat to the same word
        wdata_q[0] = 32'h55555555; wstrb_q[0] = 4'hF;
        writeBurst(4'h2, 32'h500, 4'd0, BURST_INCR, 1'b0, RESP_OKAY);
        bus.awid = 4'h3; bus.awaddr = 32'h500; bus.awlen = 8'd0; bus.awsize = 3'd2;
        bus.awburst = BURST_INCR; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        bus.arid = 4'h8; bus.araddr = 32'h500; bus.arlen = 8'd0; bus.arburst = BURST_INCR; bus.arvalid = 1'b1;
        bus.wdata = 32'h66666666; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0; bus.wvalid = 1'b0; bus.wlast = 1'b0;
        checkOutput("rdw_rvalid", 32'(bus.rvalid), 32'd1);
        checkOutput("rdw_old_data", bus.rdata, 32'h55555555);
        checkOutput("rdw_bvalid", 32'(bus.bvalid), 32'd1);
        checkOutput("rdw_bid", 32'(bus.bid), 32'h3);
        bus.rready = 1'b1; bus.bready = 1'b1;
        tick();
        bus.rready = 1'b0; bus.bready = 1'b0;
        checkOutput("rdw_done", 32'({bus.rvalid, bus.bvalid}), 32'd0);
        rexp_q[0] = 32'h66666666;
        readBurst(4'h8, 32'h500, 4'd0, BURST_INCR);

        // Asynchronous reset mid read burst
        bus.arid = 4'hB; bus.araddr = 32'h200; bus.arlen = 8'd3; bus.arburst = BURST_INCR;
        bus.arvalid = 1'b1; bus.rready = 1'b0;
        tick();
        bus.arvalid = 1'b0;
        checkOutput("pre_rst_rvalid", 32'(bus.rvalid), 32'd1);
        #2 aresetn = 1'b0;
        #1;
        checkOutput("async_rst_rvalid", 32'(bus.rvalid), 32'd0);
        checkOutput("async_rst_arready", 32'(bus.arready), 32'd1);
        checkOutput("async_rst_rdata", bus.rdata, 32'd0);
        tick();
        aresetn = 1'b1;
        tick();
        rexp_q[0] = 32'hDEADBEEF;
        readBurst(4'hD, 32'h100, 4'd0, BURST_INCR);
        for (int i = 0; i < 4; i++) rexp_q[i] = 32'(i + 1);
        readBurst(4'hE, 32'h200, 4'd3, BURST_INCR);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        applyStimulus();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
